// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operands and opcode in, result and status out.
interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic [3:0]       ALUControl;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] ALUOutput;
   logic             Zero;

   modport master (
      output Start, SrcA, SrcB, ALUControl,
      input  Busy, Done, ALUOutput, Zero
   );

   modport slave (
      input  Start, SrcA, SrcB, ALUControl,
      output Busy, Done, ALUOutput, Zero
   );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops complete in one clock; unsigned divu/remu use a
// restoring shift-subtract divider producing one quotient bit per clock.
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic        clk,
   input logic        reset,
   seq_alu_if.slave   bus
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [0:0] {IDLE, DIVIDE} state_t;

   state_t           r_state, w_state_next;
   logic [WIDTH-1:0] r_out, w_out_next;
   logic             r_zero;
   logic             r_done, w_done_next;
   logic [WIDTH-1:0] r_rem, w_rem_next;
   logic [WIDTH-1:0] r_quo, w_quo_next;
   logic [WIDTH-1:0] r_div, w_div_next;
   logic [CW-1:0]    r_count, w_count_next;
   logic             r_is_rem, w_is_rem_next;

   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_alu;
   logic             w_is_div_op;

   logic [WIDTH-1:0] w_step_rem_in, w_step_quo_in, w_step_div;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH-1:0] w_step_rem, w_step_quo;

   always_comb begin
      w_shamt = bus.SrcB[SHW-1:0];
      w_alu   = '0;
      case (bus.ALUControl)
         4'd0:    w_alu = bus.SrcA + bus.SrcB;
         4'd1:    w_alu = bus.SrcA << w_shamt;
         4'd2:    w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
         4'd3:    w_alu = bus.SrcA - bus.SrcB;
         4'd5:    w_alu = bus.SrcA >> w_shamt;
         4'd7:    w_alu = bus.SrcA & bus.SrcB;
         4'd8:    w_alu = bus.SrcB;
         4'd9:    w_alu = $signed(bus.SrcA) >>> w_shamt;
         4'd10:   w_alu = bus.SrcA | bus.SrcB;
         4'd11:   w_alu = bus.SrcA ^ bus.SrcB;
         4'd12:   w_alu = {{(WIDTH-1){1'b0}}, (bus.SrcA < bus.SrcB)};
         default: w_alu = '0;
      endcase
   end

   assign w_is_div_op = (bus.ALUControl == 4'd4) || (bus.ALUControl == 4'd6);

   // The accepting edge already performs the first divider step, so the DIVIDE
   // state needs only WIDTH-1 edges to finish the remaining quotient bits.
   always_comb begin
      if (r_state == IDLE) begin
         w_step_rem_in = '0;
         w_step_quo_in = bus.SrcA;
         w_step_div    = bus.SrcB;
      end else begin
         w_step_rem_in = r_rem;
         w_step_quo_in = r_quo;
         w_step_div    = r_div;
      end
      w_trial = {w_step_rem_in, w_step_quo_in[WIDTH-1]} - {1'b0, w_step_div};
      if (!w_trial[WIDTH]) begin
         w_step_rem = w_trial[WIDTH-1:0];
         w_step_quo = {w_step_quo_in[WIDTH-2:0], 1'b1};
      end else begin
         w_step_rem = {w_step_rem_in[WIDTH-2:0], w_step_quo_in[WIDTH-1]};
         w_step_quo = {w_step_quo_in[WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_out_next    = r_out;
      w_done_next   = 1'b0;
      w_rem_next    = r_rem;
      w_quo_next    = r_quo;
      w_div_next    = r_div;
      w_count_next  = r_count;
      w_is_rem_next = r_is_rem;
      case (r_state)
         IDLE: begin
            if (bus.Start) begin
               if (w_is_div_op && (bus.SrcB == '0)) begin
                  w_out_next  = (bus.ALUControl == 4'd4) ? '1 : bus.SrcA;
                  w_done_next = 1'b1;
               end else if (w_is_div_op) begin
                  w_state_next  = DIVIDE;
                  w_rem_next    = w_step_rem;
                  w_quo_next    = w_step_quo;
                  w_div_next    = bus.SrcB;
                  w_count_next  = '0;
                  w_is_rem_next = (bus.ALUControl == 4'd6);
               end else begin
                  w_out_next  = w_alu;
                  w_done_next = 1'b1;
               end
            end
         end
         DIVIDE: begin
            w_rem_next   = w_step_rem;
            w_quo_next   = w_step_quo;
            w_count_next = r_count + CW'(1);
            if (r_count == CW'(WIDTH - 2)) begin
               w_out_next   = r_is_rem ? w_step_rem : w_step_quo;
               w_done_next  = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_out    <= '0;
         r_zero   <= 1'b1;
         r_done   <= 1'b0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_count  <= '0;
         r_is_rem <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_out    <= w_out_next;
         r_zero   <= (w_out_next == '0);
         r_done   <= w_done_next;
         r_rem    <= w_rem_next;
         r_quo    <= w_quo_next;
         r_div    <= w_div_next;
         r_count  <= w_count_next;
         r_is_rem <= w_is_rem_next;
      end
   end

   assign bus.Busy      = (r_state == DIVIDE);
   assign bus.Done      = r_done;
   assign bus.ALUOutput = r_out;
   assign bus.Zero      = r_zero;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32) with hand-computed expected results.
module tb_seq_alu;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   seq_alu_if #(.WIDTH(32)) bus ();

   seq_alu #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end else begin
         $display("check %s: got=%08h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one request for a single edge, then drops Start.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.Start      = 1'b1;
      bus.ALUControl = op;
      bus.SrcA       = a;
      bus.SrcB       = b;
      tick();
      bus.Start = 1'b0;
   endtask

   task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      issue(op, a, b);
      chk({tag, "_done"}, {31'd0, bus.Done}, 32'd1);
      chk({tag, "_busy"}, {31'd0, bus.Busy}, 32'd0);
      chk({tag, "_out"}, bus.ALUOutput, exp);
      chk({tag, "_zero"}, {31'd0, bus.Zero}, {31'd0, (exp == 32'd0)});
   endtask

   // Runs a divide, pulsing Start with other operands while busy.
   task automatic run_div(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
      int k;
      int busy_cnt;
      int both;
      k = 1;
      busy_cnt = 0;
      both = 0;
      issue(op, a, b);
      while (!bus.Done && k < 45) begin
         if (bus.Busy) busy_cnt++;
         if (k == 5) begin
            bus.Start      = 1'b1;
            bus.ALUControl = 4'd0;
            bus.SrcA       = 32'd1;
            bus.SrcB       = 32'd1;
         end else begin
            bus.Start = 1'b0;
         end
         tick();
         k++;
      end
      bus.Start = 1'b0;
      if (bus.Done && bus.Busy) both = 1;
      chk({tag, "_latency"}, k, 32);
      chk({tag, "_busy_cycles"}, busy_cnt, 31);
      chk({tag, "_done_busy_overlap"}, both, 0);
      chk({tag, "_out"}, bus.ALUOutput, exp);
      chk({tag, "_zero"}, {31'd0, bus.Zero}, {31'd0, (exp == 32'd0)});
      tick();
      chk({tag, "_done_drop"}, {31'd0, bus.Done}, 32'd0);
      chk({tag, "_hold"}, bus.ALUOutput, exp);
   endtask

   initial begin
      int dones;
      n_checks = 0;
      n_errors = 0;
      bus.Start      = 1'b0;
      bus.SrcA       = '0;
      bus.SrcB       = '0;
      bus.ALUControl = '0;
      reset = 1'b1;
      tick();
      tick();
      chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
      chk("rst_done", {31'd0, bus.Done}, 32'd0);
      chk("rst_out", bus.ALUOutput, 32'd0);
      chk("rst_zero", {31'd0, bus.Zero}, 32'd1);

      // First cycle after reset release carries a request.
      reset = 1'b0;
      single("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0);
      tick();
      chk("add_done_drop", {31'd0, bus.Done}, 32'd0);
      single("pass_b", 4'd8, 32'hDEAD_BEEF, 32'h1234, 32'h0000_1234);

      single("sra", 4'd9, 32'h8000_0000, 32'h24, 32'hF800_0000);
      single("srl", 4'd5, 32'h8000_0000, 32'h24, 32'h0800_0000);
      single("sll", 4'd1, 32'h1, 32'h3F, 32'h8000_0000);
      single("slt", 4'd2, 32'hFFFF_FFFF, 32'h1, 32'h1);
      single("sltu", 4'd12, 32'hFFFF_FFFF, 32'h1, 32'h0);
      single("and", 4'd7, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
      single("or", 4'd10, 32'hF000_0001, 32'h0000_0010, 32'hF000_0011);
      single("op13", 4'd13, 32'h5, 32'h7, 32'h0);

      run_div("divu_100_7", 4'd4, 32'd100, 32'd7, 32'd14);
      run_div("remu_100_7", 4'd6, 32'd100, 32'd7, 32'd2);
      run_div("divu_max_16", 4'd4, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);
      run_div("remu_max_16", 4'd6, 32'hFFFF_FFFF, 32'h10, 32'hF);

      single("divu_by0", 4'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
      tick();
      chk("divu_by0_nobusy", {31'd0, bus.Busy}, 32'd0);
      single("remu_by0", 4'd6, 32'd5, 32'd0, 32'd5);
      tick();
      chk("remu_by0_nobusy", {31'd0, bus.Busy}, 32'd0);

      // Abort a divide at cycle 10.
      issue(4'd4, 32'd1000, 32'd3);
      for (int i = 0; i < 9; i++) tick();
      chk("abort_busy_before", {31'd0, bus.Busy}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", {31'd0, bus.Busy}, 32'd0);
      chk("abort_done", {31'd0, bus.Done}, 32'd0);
      chk("abort_out", bus.ALUOutput, 32'd0);
      chk("abort_zero", {31'd0, bus.Zero}, 32'd1);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.Done) dones++;
         tick();
      end
      chk("abort_no_done", dones, 0);
      single("after_abort_add", 4'd0, 32'd2, 32'd3, 32'd5);

      // Start held high across three consecutive requests.
      bus.Start      = 1'b1;
      bus.ALUControl = 4'd0;
      bus.SrcA       = 32'd10;
      bus.SrcB       = 32'd5;
      tick();
      chk("b2b_add_done", {31'd0, bus.Done}, 32'd1);
      chk("b2b_add_out", bus.ALUOutput, 32'd15);
      bus.ALUControl = 4'd3;
      bus.SrcA       = 32'd10;
      bus.SrcB       = 32'd3;
      tick();
      chk("b2b_sub_done", {31'd0, bus.Done}, 32'd1);
      chk("b2b_sub_out", bus.ALUOutput, 32'd7);
      bus.ALUControl = 4'd11;
      bus.SrcA       = 32'hF0;
      bus.SrcB       = 32'hFF;
      tick();
      bus.Start = 1'b0;
      chk("b2b_xor_done", {31'd0, bus.Done}, 32'd1);
      chk("b2b_xor_out", bus.ALUOutput, 32'h0F);
      tick();
      chk("b2b_done_drop", {31'd0, bus.Done}, 32'd0);
      chk("b2b_hold", bus.ALUOutput, 32'h0F);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits; SHALL be a power of two, 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount bits taken from SrcB[SHW-1:0].
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  request; the operation is accepted on a rising edge when Start=1 and Busy=0.
REQ-006 SrcA  input  WIDTH  operand A, sampled only at acceptance.
REQ-007 SrcB  input  WIDTH  operand B, sampled only at acceptance.
REQ-008 ALUControl  input  4  operation select, sampled only at acceptance.
REQ-009 Busy  output  1  high while a multi-cycle division is in progress.
REQ-010 Done  output  1  one-cycle pulse; ALUOutput and Zero are valid and new in this cycle.
REQ-011 ALUOutput  output  WIDTH  registered result, held until the next completion.
REQ-012 Zero  output  1  registered; 1 when ALUOutput==0.

Function
REQ-013 The ALUControl encoding SHALL be:
  - 0 add, 1 sll, 2 slt (signed), 3 sub, 4 divu, 5 srl, 6 remu, 7 and, 8 pass SrcB, 9 sra, 10 or, 11 xor, 12 sltu.
  - 13..15 produce 0.
REQ-014 Arithmetic SHALL be modulo 2^WIDTH; slt/sltu SHALL produce 1 or 0 zero-extended to WIDTH.
REQ-015 Shifts SHALL use only SrcB[SHW-1:0]; sra SHALL replicate SrcA[WIDTH-1].
REQ-016 The FSM SHALL have states IDLE and DIVIDE; reset SHALL enter IDLE.
REQ-017 IDLE, accepted non-divide op (any code except 4 or 6): result registered at the accepting edge, Done=1 in the following cycle, state stays IDLE (latency 1).
REQ-018 IDLE, accepted op 4 or 6 with SrcB!=0: go to DIVIDE, load the operands, clear the iteration counter, Busy=1 from the next cycle.
REQ-019 DIVIDE SHALL run an unsigned restoring shift-subtract algorithm producing one quotient bit per cycle for exactly WIDTH cycles.
REQ-020 On the final DIVIDE edge, the FSM SHALL:
  - register the quotient (op 4) or remainder (op 6) into ALUOutput;
  - set Done=1 and Busy=0;
  - return to IDLE.
  - Total latency is WIDTH cycles from acceptance.
REQ-021 Division by zero SHALL complete with latency 1 and no DIVIDE entry: divu returns all ones, remu returns SrcA.
REQ-022 Start while Busy=1 SHALL be ignored; operands SHALL not be re-sampled.
REQ-023 A new Start SHALL be accepted in the same cycle Done=1 (back-to-back issue); Done is high again one cycle later for single-cycle ops.
REQ-024 Done SHALL be 0 in every cycle not immediately following a completion edge; Done and Busy SHALL never both be 1.
REQ-025 ALUOutput and Zero SHALL change only on completion edges or reset.
REQ-026 Zero SHALL be computed from the value being registered into ALUOutput, in the same edge.

Reset
REQ-027 reset=1 at an edge SHALL force:
  - state=IDLE, Busy=0, Done=0, ALUOutput=0, Zero=1;
  - iteration counter and divider registers cleared.
REQ-028 Reset SHALL take priority over Start and abort any in-progress division without a Done pulse.
REQ-029 A Start present in the first cycle after reset deasserts SHALL be accepted normally.

Verification (WIDTH=32)
REQ-030 Add wrap: add 0xFFFFFFFF+0x1 -> next cycle Done=1, ALUOutput=0, Zero=1; pass SrcB 0x1234 -> 0x00001234, Zero=0.
REQ-031 Divide: divu 100/7 -> Busy=1 for 31 cycles, Done on cycle 32, ALUOutput=14; remu 100/7 -> 2 at cycle 32; Start pulses during Busy ignored, result unchanged.
REQ-032 Divide by zero: divu 5/0 -> latency 1, ALUOutput=0xFFFFFFFF, Busy never 1; remu 5/0 -> 5.
REQ-033 Shifts and compares: sra 0x80000000 by 0x24 -> 0xF8000000; srl same -> 0x08000000; slt 0xFFFFFFFF,1 -> 1; sltu same -> 0.
REQ-034 Reset mid-divide: reset at cycle 10 of divu 1000/3 -> Busy=0, Done=0, ALUOutput=0, Zero=1, no later Done; next Start add 2+3 -> Done next cycle, ALUOutput=5.
REQ-035 Back-to-back: Start held high with add, sub, xor on consecutive cycles -> three consecutive Done pulses with the correct results in order.
